// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the combinational ALU: accepts one instruction every
// three cycles, reads operands from an 8-entry register file and commits result and flags.
module alu_issue_ctrl #(
    parameter int BW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [15:0]   instr,
    output logic [BW-1:0] alu_a,
    output logic [BW-1:0] alu_b,
    output logic [3:0]    alu_opcode,
    input  logic [BW-1:0] alu_out,
    input  logic [2:0]    alu_flags,
    output logic          done,
    output logic          err,
    output logic [2:0]    status_flags,
    input  logic [2:0]    dbg_addr,
    output logic [BW-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'b1000;
    localparam logic [3:0] OP_PASS = 4'b0110;

    state_t        state_q, state_d;
    logic [2:0]    rd_q;
    logic          illegal_q;
    logic [BW-1:0] alu_a_q, alu_a_d;
    logic [BW-1:0] alu_b_q, alu_b_d;
    logic [3:0]    alu_opcode_q, alu_opcode_d;
    logic [2:0]    status_q;
    logic [BW-1:0] rf_q [8];

    logic [3:0]    op;
    logic          is_ldi;
    logic          is_illegal;
    logic          accept;
    logic          wb_en;

    function automatic logic [BW-1:0] sext_imm9(input logic [8:0] imm);
        logic signed [8:0] imm_s;
        imm_s = signed'(imm);
        return BW'(imm_s);
    endfunction

    assign op         = instr[15:12];
    assign is_ldi     = (op == OP_LDI);
    assign is_illegal = op[3] && (op[2:0] != 3'b000);
    assign accept     = (state_q == IDLE) && instr_valid;
    // Illegal opcodes still walk EXEC/WB so they retire with err, but never commit.
    assign wb_en      = (state_q == EXEC) && !illegal_q;

    // Operand selection from the incoming instruction (used only on the accepting edge)
    always_comb begin
        alu_a_d      = rf_q[instr[8:6]];
        alu_b_d      = rf_q[instr[5:3]];
        alu_opcode_d = {1'b0, op[2:0]};
        if (is_ldi) begin
            alu_a_d      = sext_imm9(instr[8:0]);
            alu_b_d      = '0;
            alu_opcode_d = OP_PASS;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (state_q)
            IDLE: instr_ready = 1'b1;
            WB: begin
                done = 1'b1;
                err  = illegal_q;
            end
            default: ;
        endcase
    end

    // T0 captures operands and destination; T1 commits the settled ALU result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q         <= '0;
            illegal_q    <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= '0;
            status_q     <= '0;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                rd_q         <= instr[11:9];
                illegal_q    <= is_illegal;
                alu_a_q      <= alu_a_d;
                alu_b_q      <= alu_b_d;
                alu_opcode_q <= alu_opcode_d;
            end
            if (wb_en) begin
                rf_q[rd_q] <= alu_out;
                status_q   <= alu_flags;
            end
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_opcode   = alu_opcode_q;
    assign status_flags = status_q;
    assign dbg_data     = rf_q[dbg_addr];

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/writeback controller that feeds the team's combinational ALU and consumes its result.
- Accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 8-entry register file.
- Drives registered operands and opcode to the ALU, then writes the ALU result back to the register file and latches the ALU flags into a status register.
- One instruction in flight; fixed 3-cycle initiation interval.

Parameters:
- BW, 16, datapath bitwidth; must match the ALU BW and be at least 9.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- instr_valid  input  1  instruction present
- instr_ready  output  1  controller can accept an instruction
- instr  input  16  instruction word
- alu_a  output  BW  ALU operand A (registered)
- alu_b  output  BW  ALU operand B (registered)
- alu_opcode  output  4  ALU opcode (registered)
- alu_out  input  BW  ALU result
- alu_flags  input  3  ALU flags {overflow, negative, zero}
- done  output  1  one-cycle pulse when an instruction retires
- err  output  1  valid with done: illegal opcode retired
- status_flags  output  3  last committed {overflow, negative, zero}
- dbg_addr  input  3  debug register-file read address
- dbg_data  output  BW  combinational read of regfile[dbg_addr]

Behaviour:
- Clock and reset:
  - Single clock is clk.
  - Reset is synchronous, active-low (rst_n), sampled on the rising clk edge.
- Instruction format:
  - instr[15:12] = op.
  - instr[11:9] = rd.
  - instr[8:6] = ra.
  - instr[5:3] = rb.
  - instr[8:0] = imm9, used for LDI only.
- Opcodes:
  - 0000–0111: ALU ops. alu_opcode = {1'b0, op[2:0]}, alu_a = R[ra], alu_b = R[rb].
  - 1000 (LDI): alu_a = sign-extended imm9, alu_b = 0, alu_opcode = 0110 (pass A). The result and flags commit like any ALU op.
  - 1001–1111: illegal. No regfile or flag update; retires with err = 1.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - instr_ready = 1.
  - On instr_valid && instr_ready at edge T0: latch op/rd, load alu_a/alu_b/alu_opcode from the regfile, go to EXEC.
  - Without a handshake: stay in IDLE.
- EXEC:
  - instr_ready = 0; the ALU output settles combinationally.
  - At edge T1, for a legal op: R[rd] <= alu_out and status_flags <= alu_flags.
  - Go to WB.
- WB:
  - instr_ready = 0, done = 1, err = illegal.
  - At edge T2, go to IDLE.
- Timing:
  - The next accept is possible at T3, so throughput is one instruction per 3 cycles.
  - A write at T1 is visible to an instruction accepted at T3 (no hazards).
- Handshake rules:
  - instr is sampled only on the accepting edge.
  - instr_valid may stay high across instructions.
  - A de-asserted instr_valid leaves the FSM in IDLE.
- Arithmetic:
  - All width, wrap and flag semantics belong to the ALU; this block does no arithmetic.
  - alu_out is written modulo 2^BW.
  - rd = ra = rb is legal; the operand was captured at T0.
- Outputs outside EXEC: alu_a, alu_b and alu_opcode hold their last values.
- Reset (rst_n low at an edge):
  - state = IDLE, all 8 registers = 0, status_flags = 000.
  - alu_a = 0, alu_b = 0, alu_opcode = 0, done = 0, err = 0.
  - A reset during EXEC or WB aborts the instruction: no write, no done pulse.
- After the reset edge, instr_ready = 1 in the first cycle with rst_n high.
- dbg_data is a pure combinational read; it reflects a write in the cycle after T1.

Test Plan:
- Basic add: LDI r1,5; LDI r2,3; ADD r3=r1+r2 (0000,011,001,010) -> dbg r3 = 0x0008, status_flags = 000, three done pulses each 3 cycles apart, err = 0.
- Overflow: LDI r1,255, then ADD r1=r1+r1 seven times -> r1 = 0x7F80. Then ADD r3=r1+r1 -> r3 = 0xFF00, status_flags = 110.
- Zero and negative: LDI r2,3; SUB r4=r2-r2 -> r4 = 0, flags = 001. LDI r5,-1 -> r5 = 0xFFFF, flags = 010.
- Illegal op: instr = 0xA000 after state r1 = 5, flags = 001 -> done with err = 1; r0–r7 and flags unchanged.
- Backpressure: instr_valid held high with 4 back-to-back LDI -> instr_ready pattern 1,0,0 repeating; exactly 4 accepts in 12 cycles; instr changes while ready = 0 are ignored.
- Mid-op reset: accept LDI r6,7, assert rst_n = 0 during EXEC -> r6 = 0, no done, instr_ready = 1 one cycle after rst_n returns high.
